roberto_rx_comando: RTL and testbench
=====================================

// Module: roberto_rx_comando
// PURPOSE
//  Serial receiver for the Spilling host link: UART 8N1 deserialiser plus command-frame parser.
//  It is the inbound counterpart of the roberto measurement transmitter (partida_tx/saida_serial).
//  Host frames "#<op>\n" become single-cycle command strobes for roberto_uc: jogar, parar, zera.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per bit (50 MHz / 115200); minimum 4; sims use 8
//  CNT_W         9    width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT
// PORTS
//  clock          in   1  system clock; all logic on the rising edge
//  reset          in   1  asynchronous, active-low reset
//  entrada_serial in   1  RX line; idles high; asynchronous to clock
//  dado_recebido  out  8  last good byte; updated only when pronto_rx=1
//  pronto_rx      out  1  1-cycle strobe: a byte with a valid stop bit was received
//  erro_framing   out  1  1-cycle strobe: stop bit sampled as 0
//  cmd_jogar      out  1  1-cycle strobe: frame "#J\n" received
//  cmd_parar      out  1  1-cycle strobe: frame "#P\n" received
//  cmd_zera       out  1  1-cycle strobe: frame "#Z\n" received
//  erro_comando   out  1  1-cycle strobe: malformed frame or unknown opcode
//  db_estado_rx   out  3  RX FSM state encoding, for the 7-segment display
//  db_estado_cmd  out  2  parser FSM state encoding
// BEHAVIOUR
//  Reset: all strobes=0; dado_recebido=8'h00; RX=OCIOSO; parser=ESPERA_INI; synchroniser flops=1.
//  Input path: 2-flop synchroniser, so 2 cycles of latency. The FSMs see only the synchronised line (rx_s).
//  RX FSM (db_estado_rx encoding):
//   OCIOSO 0    : rx_s=0 -> INICIO; counter cleared.
//   INICIO 1    : wait CLKS_PER_BIT/2 cycles (integer division), then sample.
//                 rx_s=0 -> DADOS. rx_s=1 -> OCIOSO (glitch; no strobe).
//   DADOS 2     : every CLKS_PER_BIT cycles, sample one bit. LSB first, shifted into an 8-bit register.
//                 After the 8th sample -> PARADA.
//   PARADA 3    : after CLKS_PER_BIT cycles, sample.
//                 rx_s=1 -> PRONTO.
//                 rx_s=0 -> erro_framing=1 for 1 cycle; byte discarded; -> ESPERA_ALTO.
//   PRONTO 4    : one cycle. pronto_rx=1 and dado_recebido=shift register, both in this cycle. -> OCIOSO.
//   ESPERA_ALTO 5: stay until rx_s=1, then -> OCIOSO. Breaks and stuck-low lines never retrigger.
//   Codes 6/7 are unused and return to OCIOSO.
//  Parser FSM (db_estado_cmd encoding). Acts only in cycles where pronto_rx=1:
//   ESPERA_INI 0: byte 8'h23 '#' -> ESPERA_OP. Any other byte is ignored silently.
//   ESPERA_OP 1 : latch the byte as opcode -> ESPERA_FIM. Any value is accepted, including '#'.
//   ESPERA_FIM 2: byte 8'h0A -> decode the opcode, then -> ESPERA_INI.
//                 8'h4A 'J' -> cmd_jogar; 8'h50 'P' -> cmd_parar; 8'h5A 'Z' -> cmd_zera;
//                 any other opcode -> erro_comando.
//                 Byte not 8'h0A -> erro_comando. Then -> ESPERA_OP if the byte is '#', else -> ESPERA_INI.
//   Code 3 is unused and returns to ESPERA_INI.
//  Command/error strobe timing: exactly 1 cycle, in the cycle after the pronto_rx of the terminating byte.
//  erro_framing resets the parser to ESPERA_INI in the next cycle; a partial frame is dropped and no erro_comando is raised.
//  At most one of cmd_jogar/cmd_parar/cmd_zera/erro_comando is high in any cycle.
//  Reset asserted mid-byte or mid-frame: return immediately to the reset values; no strobe fires.
//  Next start bit: a start bit arriving while RX is in PRONTO is detected one cycle later. No byte loss at full line rate.
// TESTING (CLKS_PER_BIT=8)
//  1. Send 8'hA5 with a valid stop bit -> one pronto_rx pulse, dado_recebido=8'hA5, no erro_framing.
//  2. Send "#J\n" back-to-back -> three pronto_rx pulses;
//     cmd_jogar high 1 cycle, exactly 1 cycle after the third pronto_rx; no other strobe.
//  3. Send "#X\n" -> erro_comando pulse only. Then "##P\n" -> erro_comando? no: '#' taken as opcode, 'P' not 8'h0A
//     -> erro_comando, parser -> ESPERA_INI; the following '\n' is ignored; no cmd_parar.
//  4. Byte 8'h3C with stop bit forced 0, line held low 40 cycles -> one erro_framing pulse; no pronto_rx;
//     RX stays in ESPERA_ALTO until the line goes high; a following "#Z\n" yields cmd_zera.
//  5. 3-cycle low glitch on an idle line -> RX returns to OCIOSO; no pronto_rx and no erro_framing.
//  6. Assert reset during the 4th data bit of '#', release, then send "#J\n"
//     -> all outputs 0 while in reset; exactly one cmd_jogar afterwards.

Source files
------------

// File: rtl/roberto_rx_comando.sv
// Spilling host-link receiver: UART 8N1 deserialiser feeding a "#<op>\n" command parser
// that produces single-cycle jogar/parar/zera strobes for roberto_uc.
module roberto_rx_comando #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [7:0] dado_recebido,
    output logic       pronto_rx,
    output logic       erro_framing,
    output logic       cmd_jogar,
    output logic       cmd_parar,
    output logic       cmd_zera,
    output logic       erro_comando,
    output logic [2:0] db_estado_rx,
    output logic [1:0] db_estado_cmd
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [7:0]  CH_HASH  = 8'h23;
    localparam logic [7:0]  CH_LF    = 8'h0A;
    localparam logic [7:0]  CH_J     = 8'h4A;
    localparam logic [7:0]  CH_P     = 8'h50;
    localparam logic [7:0]  CH_Z     = 8'h5A;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        INICIO      = 3'd1,
        DADOS       = 3'd2,
        PARADA      = 3'd3,
        PRONTO      = 3'd4,
        ESPERA_ALTO = 3'd5
    } rx_state_t;

    typedef enum logic [1:0] {
        ESPERA_INI = 2'd0,
        ESPERA_OP  = 2'd1,
        ESPERA_FIM = 2'd2
    } cmd_state_t;

    logic [1:0]       sync_q;
    logic             rx_s;

    rx_state_t        rx_q, rx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       nbit_q, nbit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       dado_q, dado_d;
    logic             pronto_q, pronto_d;
    logic             ferr_q, ferr_d;

    cmd_state_t       cs_q, cs_d;
    logic [7:0]       op_q, op_d;
    logic             jog_q, jog_d;
    logic             par_q, par_d;
    logic             zera_q, zera_d;
    logic             ecmd_q, ecmd_d;

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], entrada_serial};
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_q     <= OCIOSO;
            cnt_q    <= '0;
            nbit_q   <= '0;
            shift_q  <= '0;
            dado_q   <= '0;
            pronto_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            rx_q     <= rx_d;
            cnt_q    <= cnt_d;
            nbit_q   <= nbit_d;
            shift_q  <= shift_d;
            dado_q   <= dado_d;
            pronto_q <= pronto_d;
            ferr_q   <= ferr_d;
        end
    end

    // Bit timing: start bit checked at mid-bit, then each later sample one full bit apart
    always_comb begin
        rx_d     = rx_q;
        cnt_d    = cnt_q;
        nbit_d   = nbit_q;
        shift_d  = shift_q;
        dado_d   = dado_q;
        pronto_d = 1'b0;
        ferr_d   = 1'b0;
        case (rx_q)
            OCIOSO: begin
                cnt_d  = '0;
                nbit_d = '0;
                if (!rx_s) rx_d = INICIO;
            end
            INICIO: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d = '0;
                    rx_d  = rx_s ? OCIOSO : DADOS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DADOS: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    nbit_d  = nbit_q + 3'd1;
                    if (nbit_q == 3'd7) rx_d = PARADA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARADA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_d     = PRONTO;
                        pronto_d = 1'b1;
                        dado_d   = shift_q;
                    end else begin
                        rx_d   = ESPERA_ALTO;
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRONTO: begin
                rx_d = OCIOSO;
            end
            ESPERA_ALTO: begin
                if (rx_s) rx_d = OCIOSO;
            end
            default: begin
                rx_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cs_q   <= ESPERA_INI;
            op_q   <= '0;
            jog_q  <= 1'b0;
            par_q  <= 1'b0;
            zera_q <= 1'b0;
            ecmd_q <= 1'b0;
        end else begin
            cs_q   <= cs_d;
            op_q   <= op_d;
            jog_q  <= jog_d;
            par_q  <= par_d;
            zera_q <= zera_d;
            ecmd_q <= ecmd_d;
        end
    end

    // Frame parser; a framing error drops any partial frame without reporting it
    always_comb begin
        cs_d   = cs_q;
        op_d   = op_q;
        jog_d  = 1'b0;
        par_d  = 1'b0;
        zera_d = 1'b0;
        ecmd_d = 1'b0;
        case (cs_q)
            ESPERA_INI: begin
                if (pronto_q && dado_q == CH_HASH) cs_d = ESPERA_OP;
            end
            ESPERA_OP: begin
                if (ferr_q) begin
                    cs_d = ESPERA_INI;
                end else if (pronto_q) begin
                    op_d = dado_q;
                    cs_d = ESPERA_FIM;
                end
            end
            ESPERA_FIM: begin
                if (ferr_q) begin
                    cs_d = ESPERA_INI;
                end else if (pronto_q) begin
                    if (dado_q == CH_LF) begin
                        cs_d = ESPERA_INI;
                        case (op_q)
                            CH_J:    jog_d  = 1'b1;
                            CH_P:    par_d  = 1'b1;
                            CH_Z:    zera_d = 1'b1;
                            default: ecmd_d = 1'b1;
                        endcase
                    end else begin
                        ecmd_d = 1'b1;
                        cs_d   = (dado_q == CH_HASH) ? ESPERA_OP : ESPERA_INI;
                    end
                end
            end
            default: begin
                cs_d = ESPERA_INI;
            end
        endcase
    end

    assign dado_recebido = dado_q;
    assign pronto_rx     = pronto_q;
    assign erro_framing  = ferr_q;
    assign cmd_jogar     = jog_q;
    assign cmd_parar     = par_q;
    assign cmd_zera      = zera_q;
    assign erro_comando  = ecmd_q;
    assign db_estado_rx  = rx_q;
    assign db_estado_cmd = cs_q;

endmodule

// File: tb/tb_roberto_rx_comando.sv
// Scoreboard bench for roberto_rx_comando: stimulus queues expected strobe events,
// an independent monitor pops and checks them whenever any strobe is observed.
module tb_roberto_rx_comando;

    localparam int unsigned CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line = 1'b1;
    logic [7:0] dado_recebido;
    logic       pronto_rx, erro_framing, cmd_jogar, cmd_parar, cmd_zera, erro_comando;
    logic [2:0] db_estado_rx;
    logic [1:0] db_estado_cmd;

    roberto_rx_comando #(.CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
        .clock          (clk),
        .reset          (rst_n),
        .entrada_serial (line),
        .dado_recebido  (dado_recebido),
        .pronto_rx      (pronto_rx),
        .erro_framing   (erro_framing),
        .cmd_jogar      (cmd_jogar),
        .cmd_parar      (cmd_parar),
        .cmd_zera       (cmd_zera),
        .erro_comando   (erro_comando),
        .db_estado_rx   (db_estado_rx),
        .db_estado_cmd  (db_estado_cmd)
    );

    always #5 clk = ~clk;

    // Event bits: pronto, framing, jogar, parar, zera, erro_comando
    localparam logic [5:0] EV_PRONTO = 6'b100000;
    localparam logic [5:0] EV_FERR   = 6'b010000;
    localparam logic [5:0] EV_JOG    = 6'b001000;
    localparam logic [5:0] EV_PAR    = 6'b000100;
    localparam logic [5:0] EV_ZERA   = 6'b000010;
    localparam logic [5:0] EV_ECMD   = 6'b000001;

    typedef struct packed {
        logic [5:0] ev;
        logic [7:0] data;
        logic       after_pronto;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   last_pronto = -10;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
        end
    endtask

    // Monitor: one scoreboard comparison per cycle with any strobe high
    initial begin
        logic [5:0] ev;
        exp_t       e;
        logic       ok;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            ev = {pronto_rx, erro_framing, cmd_jogar, cmd_parar, cmd_zera, erro_comando};
            if (ev != 6'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got ev=%b data=%02h required none (cycle %0d)",
                             ev, dado_recebido, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (ev == e.ev) && (!ev[5] || dado_recebido == e.data) &&
                         (!e.after_pronto || cyc == last_pronto + 1);
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL event: got ev=%b data=%02h dt=%0d required ev=%b data=%02h after_pronto=%0b",
                                 ev, dado_recebido, cyc - last_pronto, e.ev, e.data, e.after_pronto);
                    end
                end
                if (ev[5]) last_pronto = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            repeat (CPB) @(negedge clk);
        end
        line = stop;
        repeat (CPB) @(negedge clk);
        line = 1'b1;
    endtask

    task automatic push(input logic [5:0] ev, input logic [7:0] d, input logic ap);
        exp_t e;
        e.ev = ev; e.data = d; e.after_pronto = ap;
        exp_q.push_back(e);
    endtask

    task automatic push_byte(input logic [7:0] b);
        push(EV_PRONTO, b, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [5:0] cmd_ev);
        push_byte(8'h23);
        push_byte(op);
        push_byte(8'h0A);
        push(cmd_ev, 8'h00, 1'b1);
        send_byte(8'h23, 1'b1);
        send_byte(op, 1'b1);
        send_byte(8'h0A, 1'b1);
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        line  = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_outputs", 32'({dado_recebido, pronto_rx, erro_framing, cmd_jogar, cmd_parar,
                                  cmd_zera, erro_comando, db_estado_rx, db_estado_cmd}), 32'd0);
        rst_n = 1'b1;
        idle(5);
        chk("idle_rx_state", 32'(db_estado_rx), 32'd0);
        chk("idle_cmd_state", 32'(db_estado_cmd), 32'd0);

        // 1: single byte
        push_byte(8'hA5);
        send_byte(8'hA5, 1'b1);
        idle(10);
        chk("byte_hold", 32'(dado_recebido), 32'hA5);

        // 2: "#J\n" back to back
        send_frame(8'h4A, EV_JOG);
        idle(10);

        // 3: unknown opcode, then "##P\n"
        send_frame(8'h58, EV_ECMD);
        idle(10);
        push_byte(8'h23);
        push_byte(8'h23);
        push_byte(8'h50);
        push(EV_ECMD, 8'h00, 1'b1);
        push_byte(8'h0A);
        send_byte(8'h23, 1'b1);
        send_byte(8'h23, 1'b1);
        send_byte(8'h50, 1'b1);
        send_byte(8'h0A, 1'b1);
        idle(10);
        chk("parser_ini_after_lf", 32'(db_estado_cmd), 32'd0);

        // 4: framing error with stuck-low line, then "#Z\n"
        push(EV_FERR, 8'h00, 1'b0);
        send_byte(8'h3C, 1'b0);
        line = 1'b0;
        repeat (40) @(negedge clk);
        chk("espera_alto", 32'(db_estado_rx), 32'd5);
        chk("dado_kept_after_ferr", 32'(dado_recebido), 32'h0A);
        idle(10);
        chk("ocioso_after_high", 32'(db_estado_rx), 32'd0);
        send_frame(8'h5A, EV_ZERA);
        idle(10);

        // 5: short glitch
        line = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        chk("glitch_ocioso", 32'(db_estado_rx), 32'd0);

        // 6: reset during 4th data bit of '#'
        line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            line = 1'(8'h23 >> i);
            repeat (CPB) @(negedge clk);
        end
        line = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("in_reset_outputs", 32'({dado_recebido, pronto_rx, erro_framing, cmd_jogar, cmd_parar,
                                         cmd_zera, erro_comando, db_estado_rx, db_estado_cmd}), 32'd0);
        end
        line  = 1'b1;
        rst_n = 1'b1;
        idle(20);
        send_frame(8'h4A, EV_JOG);

        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        idle(20);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("final_dado", 32'(dado_recebido), 32'h0A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
